// File: rtl/sta_tile_sequencer.sv
// sta_tile_sequencer: paces one output tile through the systolic tensor array.
// A tile command latches a reduction length. Operand beats are then accepted
// under a valid/ready handshake, with the array frozen during source bubbles.
// The pipeline is flushed with zero operands for DRAIN_CYC cycles, and
// completion is signalled.
module sta_tile_sequencer #(
   parameter int N         = 32,
   parameter int M         = 32,
   parameter int K_W       = 16,
   parameter int DRAIN_CYC = N + M
) (
   input  logic           clk_i,
   input  logic           reset_ni,
   input  logic           start_i,
   input  logic [K_W-1:0] k_len_i,
   input  logic           abort_i,
   input  logic           src_valid_i,
   output logic           src_ready_o,
   output logic           array_en_o,
   output logic           zero_fill_o,
   output logic [N-1:0]   col_valid_o,
   output logic [M-1:0]   row_valid_o,
   output logic           busy_o,
   output logic           done_o,
   output logic           aborted_o
);

   localparam int DC_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
   localparam logic [DC_W-1:0] DRAIN_LAST = DC_W'(DRAIN_CYC - 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] STREAM = 2'd1;
   localparam logic [1:0] DRAIN  = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   logic [1:0]      state_reg, state_next;
   logic [K_W-1:0]  k_len_reg;
   logic [K_W-1:0]  beat_cnt_reg;
   logic [DC_W-1:0] drain_cnt_reg;
   logic [N-1:0]    col_valid_reg;
   logic [M-1:0]    row_valid_reg;
   logic            aborted_reg;

   logic in_stream;
   logic in_drain;
   logic beat_accept;
   logic last_beat;
   logic last_drain;
   logic mask_in_bit;

   assign in_stream   = (state_reg == STREAM);
   assign in_drain    = (state_reg == DRAIN);

   // An abort cycle never consumes a beat, so ready is withdrawn as well.
   assign src_ready_o = in_stream & ~abort_i;
   assign beat_accept = src_ready_o & src_valid_i;
   assign last_beat   = beat_accept & (beat_cnt_reg == (k_len_reg - K_W'(1)));
   assign last_drain  = in_drain & (drain_cnt_reg == DRAIN_LAST);

   assign array_en_o  = beat_accept | in_drain;
   assign zero_fill_o = in_drain;
   assign busy_o      = (state_reg != IDLE);
   assign done_o      = (state_reg == DONE) & ~abort_i;
   assign aborted_o   = aborted_reg;
   assign col_valid_o = col_valid_reg;
   assign row_valid_o = row_valid_reg;

   // Real operands enter the skew masks only during STREAM; drain shifts in zeros.
   assign mask_in_bit = in_stream;

   // Next-state selection; an abort from any active state returns straight to IDLE.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (start_i) begin
               state_next = (k_len_i == '0) ? DRAIN : STREAM;
            end
         end
         STREAM: begin
            if (abort_i) begin
               state_next = IDLE;
            end else if (last_beat) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (abort_i) begin
               state_next = IDLE;
            end else if (last_drain) begin
               state_next = DONE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State, length latch, beat/drain counters and the abort pulse.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_reg     <= IDLE;
         k_len_reg     <= '0;
         beat_cnt_reg  <= '0;
         drain_cnt_reg <= '0;
         aborted_reg   <= 1'b0;
      end else begin
         state_reg   <= state_next;
         aborted_reg <= abort_i & (state_reg != IDLE);

         if ((state_reg == IDLE) && start_i) begin
            k_len_reg    <= k_len_i;
            beat_cnt_reg <= '0;
         end else if (beat_accept) begin
            beat_cnt_reg <= beat_cnt_reg + K_W'(1);
         end

         if (in_drain && !last_drain) begin
            drain_cnt_reg <= drain_cnt_reg + DC_W'(1);
         end else begin
            drain_cnt_reg <= '0;
         end
      end
   end

   // Skewed operand-valid masks: shift only when the array advances, clear on return to IDLE.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         col_valid_reg <= '0;
         row_valid_reg <= '0;
      end else if (state_next == IDLE) begin
         col_valid_reg <= '0;
         row_valid_reg <= '0;
      end else if (array_en_o) begin
         col_valid_reg <= {col_valid_reg[N-2:0], mask_in_bit};
         row_valid_reg <= {row_valid_reg[M-2:0], mask_in_bit};
      end
   end

endmodule
